cassette_rec: RTL

Cassette capture decoder for the Interact core. It recovers the tape bitstream the machine writes on its cassette output line. It measures the period of the square wave on `flux`, classifies each cycle as a zero, one or gap bit, and detects the leader. It then assembles bytes LSB-first and writes them sequentially into tape image RAM, producing an image byte-compatible with what the playback block consumes.

---
 rtl/cassette_rec_if.sv | 9 +
 rtl/cassette_rec.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cassette_rec_if.sv
// Tape image RAM write port: byte address, data and a one-cycle write strobe.
interface cassette_rec_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;

  modport master (output mem_addr, mem_data, mem_wr);
  modport slave  (input  mem_addr, mem_data, mem_wr);
endinterface

// File: rtl/cassette_rec.sv
// Cassette capture decoder: flux period -> ZERO/ONE/GAP bits -> LSB-first bytes -> tape RAM.
// Optional glitch filter on the synchronised flux level: define CASSETTE_REC_FILTER_EN.
module cassette_rec #(
  parameter int MIN_LEADER = 356,
  parameter int T_MIN      = 2000,
  parameter int T_ONE      = 12500,
  parameter int T_GAP      = 20617,
  parameter int T_OUT      = 32767
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arm,
  input  logic           abort,
  input  logic           flux,
  cassette_rec_if.master mem,
  output logic [15:0]    tape_end,
  output logic           busy,
  output logic           done,
  output logic           err
);
  localparam logic [15:0] TMIN = 16'(T_MIN);
  localparam logic [15:0] TONE = 16'(T_ONE);
  localparam logic [15:0] TGAP = 16'(T_GAP);
  localparam logic [15:0] TOUT = 16'(T_OUT);
  localparam logic [9:0]  LMIN = 10'(MIN_LEADER);

  typedef enum logic [1:0] {S_IDLE, S_LEADER, S_DATA, S_DONE} state_t;
  state_t state_q, state_nx;

  logic        flux_s1, flux_s2, flux_lvl, flux_d;
  logic        arm_q, abort_q;
  logic [15:0] per_cnt;
  logic        first_pend;
  logic [9:0]  lead_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  byte_q, byte_nx;
  logic        wr_q;
  logic [7:0]  data_q;
  logic [15:0] addr_q;
  logic        full, wrote_any;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {flux_s1, flux_s2} <= 2'b00;
    else        {flux_s1, flux_s2} <= {flux, flux_s1};

`ifdef CASSETTE_REC_FILTER_EN
  // Level only follows the line after 16 consecutive agreeing samples.
  logic [3:0] flt_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flt_cnt  <= '0;
      flux_lvl <= 1'b0;
    end else if (flux_s2 == flux_lvl) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == 4'd15) begin
      flt_cnt  <= '0;
      flux_lvl <= flux_s2;
    end else begin
      flt_cnt  <= flt_cnt + 4'd1;
    end
`else
  assign flux_lvl = flux_s2;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {flux_d, arm_q, abort_q} <= 3'b000;
    else        {flux_d, arm_q, abort_q} <= {flux_lvl, arm, abort};

  logic rise, arm_rise, abort_rise, sat, cls_v, is_gap, is_one, reload;
  assign rise       = flux_lvl & ~flux_d;
  assign arm_rise   = arm & ~arm_q;
  assign abort_rise = abort & ~abort_q;
  assign sat        = (per_cnt == TOUT);
  assign cls_v      = rise && (per_cnt >= TMIN);
  assign is_gap     = (per_cnt >= TGAP);
  assign is_one     = (per_cnt >= TONE);
  // Glitch edges inside T_MIN leave the period running; the first edge of a leader always restarts it.
  assign reload     = rise && (first_pend || per_cnt >= TMIN);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       per_cnt <= '0;
    else if (reload)  per_cnt <= 16'd1;
    else if (!sat)    per_cnt <= per_cnt + 16'd1;

  logic start, lead_inc, lead_clr, first_clr, first_set, bit_v, drop_part, set_err;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_nx;

  always_comb begin
    state_nx  = state_q;
    start     = 1'b0;
    lead_inc  = 1'b0;
    lead_clr  = 1'b0;
    first_clr = 1'b0;
    first_set = 1'b0;
    bit_v     = 1'b0;
    drop_part = 1'b0;
    set_err   = 1'b0;
    if (abort_rise) begin
      state_nx = S_IDLE;
    end else if (arm_rise) begin
      state_nx = S_LEADER;
      start    = 1'b1;
    end else begin
      unique case (state_q)
        S_LEADER:
          if (rise && first_pend) begin
            first_clr = 1'b1;
          end else if (sat) begin
            lead_clr  = 1'b1;
            first_set = 1'b1;
          end else if (cls_v) begin
            if (is_gap)                  lead_inc = 1'b1;
            else if (lead_cnt >= LMIN) begin
              state_nx = S_DATA;
              bit_v    = 1'b1;
            end else                     lead_clr = 1'b1;
          end
        S_DATA:
          if (sat) begin
            state_nx = S_DONE;
            set_err  = (bit_idx != 3'd0) || !wrote_any;
          end else if (cls_v) begin
            if (!is_gap)                 bit_v     = 1'b1;
            else if (bit_idx != 3'd0)    drop_part = 1'b1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_nx          = byte_q;
    byte_nx[bit_idx] = is_one;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lead_cnt   <= '0;
      first_pend <= 1'b0;
      bit_idx    <= '0;
      byte_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      tape_end   <= '0;
      full       <= 1'b0;
      wrote_any  <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      // Address bookkeeping trails the strobe so mem_addr is stable while mem_wr is high.
      if (wr_q) begin
        tape_end  <= addr_q;
        wrote_any <= 1'b1;
        if (addr_q == 16'hFFFF) full   <= 1'b1;
        else                    addr_q <= addr_q + 16'd1;
      end
      if (lead_clr)                             lead_cnt <= '0;
      else if (lead_inc && lead_cnt != 10'h3FF) lead_cnt <= lead_cnt + 10'd1;
      if (first_clr)      first_pend <= 1'b0;
      else if (first_set) first_pend <= 1'b1;
      if (set_err) err <= 1'b1;
      if (drop_part) begin
        bit_idx <= '0;
        err     <= 1'b1;
      end
      if (bit_v) begin
        byte_q  <= byte_nx;
        bit_idx <= bit_idx + 3'd1;
        if (bit_idx == 3'd7) begin
          if (full) err <= 1'b1;
          else begin
            wr_q   <= 1'b1;
            data_q <= byte_nx;
          end
        end
      end
      if (start) begin
        lead_cnt   <= '0;
        first_pend <= 1'b1;
        bit_idx    <= '0;
        addr_q     <= '0;
        tape_end   <= '0;
        full       <= 1'b0;
        wrote_any  <= 1'b0;
        err        <= 1'b0;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_q == S_LEADER) || (state_q == S_DATA);
      done <= (state_q == S_DONE);
    end

  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign mem.mem_wr   = wr_q;
endmodule
